// File: rtl/icache_fill.sv
// Direct-mapped read-only instruction cache with a 4-word line refill over the system bus.
// Hits answer combinationally in the request cycle; a miss fills the line and the held request replays as a hit.
module icache_fill #(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_wait,
    input  logic        inv,
    output logic [31:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    localparam int unsigned LINES  = 2 ** IDX_BITS;
    localparam int unsigned LINE_W = 28;
    localparam int unsigned TAG_W  = LINE_W - IDX_BITS;
    localparam int unsigned WORDS  = LINES * 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    state_e                  state_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [WORDS];
    logic [LINE_W-1:0]       line_q;
    logic [1:0]              cnt_q;
    logic                    discard_q;
    logic                    bus_rd_q;
    logic [31:0]             bus_addr_q;

    logic [IDX_BITS-1:0]     req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [1:0]              req_word;
    logic [IDX_BITS-1:0]     fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit_c;
    logic                    unused_addr_c;

    assign req_idx  = rd_addr[4 +: IDX_BITS];
    assign req_tag  = rd_addr[31 -: TAG_W];
    assign req_word = rd_addr[3:2];
    assign fill_idx = line_q[IDX_BITS-1:0];
    assign fill_tag = line_q[LINE_W-1 -: TAG_W];

    // Byte offset within the word is ignored by the fetch path.
    assign unused_addr_c = ^rd_addr[1:0];

    // Lookup only in IDLE; uses the pre-clear valid bits even when inv is sampled this cycle.
    assign hit_c   = (state_q == ST_IDLE) && rd_req && valid_q[req_idx]
                     && (tag_q[req_idx] == req_tag);
    assign rd_wait = rd_req && !hit_c;
    assign rd_data = data_q[{req_idx, req_word}];

    assign bus_rd    = bus_rd_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wr    = 1'b0;
    assign bus_wdata = 32'h0;

    // Control FSM: lookup/miss detection, refill sequencing and valid-bit maintenance.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            line_q     <= '0;
            cnt_q      <= 2'd0;
            discard_q  <= 1'b0;
            bus_rd_q   <= 1'b0;
            bus_addr_q <= 32'h0;
        end else begin
            if (inv) begin
                valid_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    discard_q <= 1'b0;
                    if (rd_req && !hit_c) begin
                        line_q     <= rd_addr[31:4];
                        cnt_q      <= 2'd0;
                        bus_rd_q   <= 1'b1;
                        bus_addr_q <= {rd_addr[31:4], 4'h0};
                        state_q    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (inv) begin
                        discard_q <= 1'b1;
                    end
                    if (bus_ready) begin
                        cnt_q      <= cnt_q + 2'd1;
                        bus_addr_q <= {line_q, 2'(cnt_q + 2'd1), 2'b00};
                        if (cnt_q == 2'd3) begin
                            bus_rd_q <= 1'b0;
                            state_q  <= ST_IDLE;
                            // An invalidate seen at any point of the fill leaves the line invalid.
                            if (!inv && !discard_q) begin
                                valid_q[fill_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tag and data arrays: no reset, written only as bus words return during a fill.
    always_ff @(posedge clk) begin
        if ((state_q == ST_FILL) && bus_ready) begin
            data_q[{fill_idx, cnt_q}] <= bus_rdata;
            if (cnt_q == 2'd3) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

endmodule
